// File: rtl/keysched_ctrl.sv
// Iterative AES key-schedule controller: one expanded word per cycle through a shared 4-S-box bank.
// Optional KEYSCHED_EARLY_RD_EN lets a round key read as valid as soon as its four words exist.

module sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] b;
      p = 8'h00;
      b = x;
      for (int k = 0; k < 8; k++) begin
         if (z[k]) p = p ^ b;
         b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;
   logic [7:0] sq;

   // x^254 is the GF(2^8) inverse (and maps 0 to 0), followed by the affine transform.
   always_comb begin
      inv = 8'h01;
      sq  = i_byte;
      for (int k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      o_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module keysched_ctrl #(
   parameter int WORD = 32,
   parameter int NB   = 4,
   parameter int NK   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_key_valid,
   input  logic [WORD*NK-1:0]   i_key,
   output logic                 o_key_ready,
   output logic                 o_done,
   input  logic [3:0]           i_rd_round,
   output logic [NB*WORD-1:0]   o_rd_key,
   output logic                 o_rd_valid
);
   localparam int NR = NK + 6;
   localparam int NW = NB * (NR + 1);
   localparam logic [5:0] NK6   = 6'(NK);
   localparam logic [5:0] LAST  = 6'(NW - 1);
   localparam logic [2:0] MLAST = 3'(NK - 1);
   localparam logic [3:0] NR4   = 4'(NR);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [WORD-1:0] w [NW];
   logic [1:0]      state;
   logic [5:0]      idx;
   logic [2:0]      m;
   logic [7:0]      rcon;
   logic            rdy;
   logic            accept;

   logic [5:0]      prv_i;
   logic [5:0]      old_i;
   logic [WORD-1:0] prv;
   logic [WORD-1:0] sb_in;
   logic [WORD-1:0] sb_out;
   logic [WORD-1:0] t;

   assign accept      = i_key_valid & rdy;
   assign o_key_ready = rdy;
   assign o_done      = (state == S_DONE);

   assign prv_i = idx - 6'd1;
   assign old_i = idx - NK6;
   assign prv   = w[prv_i];

   for (genvar b = 0; b < 4; b++) begin : g_sb
      sbox u_sbox (.i_byte(sb_in[8*b +: 8]), .o_byte(sb_out[8*b +: 8]));
   end

   always_comb begin
      sb_in = (m == 3'd0) ? {prv[23:0], prv[31:24]} : prv;
      t     = prv;
      if (m == 3'd0)
         t = sb_out ^ {rcon, 24'h0};
      else if (NK == 8 && m == 3'd4)
         t = sb_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= 6'd0;
         m     <= 3'd0;
         rcon  <= 8'h01;
         rdy   <= 1'b0;
      end else if (accept) begin
         state <= S_EXP;
         idx   <= NK6;
         m     <= 3'd0;
         rcon  <= 8'h01;
         rdy   <= 1'b0;
      end else if (state == S_EXP) begin
         idx <= idx + 6'd1;
         m   <= (m == MLAST) ? 3'd0 : m + 3'd1;
         if (m == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         if (idx == LAST) begin
            state <= S_DONE;
            rdy   <= 1'b1;
         end
      end else begin
         rdy <= 1'b1;
      end
   end

   // The word store is never cleared; validity comes from state and idx.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) begin
            for (int k = 0; k < NK; k++) w[k] <= i_key[WORD*(NK-k)-1 -: WORD];
         end else if (state == S_EXP) begin
            w[idx] <= t ^ w[old_i];
         end
      end
   end

   logic       rd_ok;
   logic [5:0] base;
   logic       rd_vld;

   assign rd_ok = (i_rd_round <= NR4);
   assign base  = {i_rd_round, 2'b00};

`ifdef KEYSCHED_EARLY_RD_EN
   assign rd_vld = rd_ok & ((state == S_DONE) | ((state == S_EXP) & ((base + 6'd3) < idx)));
`else
   assign rd_vld = rd_ok & (state == S_DONE);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         o_rd_key   <= '0;
         o_rd_valid <= 1'b0;
      end else begin
         o_rd_valid <= rd_vld;
         o_rd_key   <= rd_ok ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
      end
   end
endmodule

// File: tb/tb_keysched_ctrl.sv
// Randomized bench for keysched_ctrl: NK=4/6/8 instances checked every cycle against a software key expansion.
module tb_keysched_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef KEYSCHED_EARLY_RD_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam int NKS  [3] = '{4, 6, 8};
   localparam int DLAT [3] = '{40, 46, 52};
   localparam logic [255:0] K4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] K6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic         kv  [3];
   logic         kr  [3];
   logic         dn  [3];
   logic         rv  [3];
   logic [255:0] key [3];
   logic [3:0]   rd  [3];
   logic [127:0] rk  [3];

   int checks = 0;
   int errors = 0;

   logic [7:0]  sb_tab [256];
   logic [31:0] exp_w  [4][60];
   bit          keyed  [3];
   int          nv     [3];
   bit          m_rdy  [3];
   bit          m_init [3];
   bit          e_rv   [3];
   bit          e_rkchk[3];
   logic [127:0] e_rk  [3];

   keysched_ctrl #(.NK(4)) u_nk4 (.clk(clk), .rst(rst), .i_key_valid(kv[0]), .i_key(key[0][127:0]),
      .o_key_ready(kr[0]), .o_done(dn[0]), .i_rd_round(rd[0]), .o_rd_key(rk[0]), .o_rd_valid(rv[0]));
   keysched_ctrl #(.NK(6)) u_nk6 (.clk(clk), .rst(rst), .i_key_valid(kv[1]), .i_key(key[1][191:0]),
      .o_key_ready(kr[1]), .o_done(dn[1]), .i_rd_round(rd[1]), .o_rd_key(rk[1]), .o_rd_valid(rv[1]));
   keysched_ctrl #(.NK(8)) u_nk8 (.clk(clk), .rst(rst), .i_key_valid(kv[2]), .i_key(key[2][255:0]),
      .o_key_ready(kr[2]), .o_done(dn[2]), .i_rd_round(rd[2]), .o_rd_key(rk[2]), .o_rd_valid(rv[2]));

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   // Inverse found by exhaustive search, affine map written bit by bit.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] s;
      logic [7:0] y;
      logic [7:0] c;
      s = 8'h00;
      c = 8'h63;
      for (int v = 1; v < 256; v++) if (x != 8'h00 && gm(x, 8'(v)) == 8'h01) s = 8'(v);
      for (int i = 0; i < 8; i++)
         y[i] = s[i] ^ s[(i+4)%8] ^ s[(i+5)%8] ^ s[(i+6)%8] ^ s[(i+7)%8] ^ c[i];
      return y;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] a);
      return {sb_tab[a[31:24]], sb_tab[a[23:16]], sb_tab[a[15:8]], sb_tab[a[7:0]]};
   endfunction

   task automatic do_expand(input int j, input int nk, input logic [255:0] k);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) exp_w[j][i] = 32'(k >> (32*(nk-1-i)));
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = exp_w[j][i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         exp_w[j][i] = exp_w[j][i-nk] ^ t;
      end
   endtask

   task automatic chk(input string nm, input int j, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, j, $time, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference model: counts of valid words, updated from the timing rules at each edge.
   always @(posedge clk) begin
      int nk, nr, nw, r;
      for (int j = 0; j < 3; j++) begin
         nk = NKS[j];
         nr = nk + 6;
         nw = 4 * (nr + 1);
         r  = int'(rd[j]);
         if (r > nr) begin
            e_rv[j]    = 1'b0;
            e_rk[j]    = '0;
            e_rkchk[j] = 1'b1;
         end else begin
            e_rv[j]    = keyed[j] && (nv[j] == nw || (EARLY && nv[j] >= 4*r+4));
            e_rk[j]    = {exp_w[j][4*r], exp_w[j][4*r+1], exp_w[j][4*r+2], exp_w[j][4*r+3]};
            e_rkchk[j] = e_rv[j];
         end
         if (rst) begin
            keyed[j]   = 1'b0;
            nv[j]      = 0;
            m_rdy[j]   = 1'b0;
            e_rv[j]    = 1'b0;
            e_rk[j]    = '0;
            e_rkchk[j] = 1'b1;
            m_init[j]  = 1'b1;
         end else if (kv[j] && m_rdy[j]) begin
            do_expand(j, nk, key[j]);
            keyed[j] = 1'b1;
            nv[j]    = nk;
            m_rdy[j] = 1'b0;
         end else begin
            if (keyed[j] && nv[j] < nw) nv[j]++;
            m_rdy[j] = !(keyed[j] && nv[j] < nw);
         end
      end
   end

   always @(negedge clk) begin
      for (int j = 0; j < 3; j++) begin
         if (m_init[j]) begin
            chk("ready", j, 128'(kr[j]), 128'(m_rdy[j]));
            chk("done", j, 128'(dn[j]), 128'(keyed[j] && nv[j] == 4*(NKS[j]+7)));
            chk("rd_valid", j, 128'(rv[j]), 128'(e_rv[j]));
            if (e_rkchk[j]) chk("rd_key", j, rk[j], e_rk[j]);
         end
      end
   end

   initial begin
      int dl [3];
      int fv;
      logic [255:0] kb;
      for (int x = 0; x < 256; x++) sb_tab[x] = sbox_ref(8'(x));
      for (int j = 0; j < 3; j++) begin
         kv[j]  = 1'b0;
         key[j] = '0;
         rd[j]  = 4'd0;
      end

      // Pin the software expansion against the FIPS-197 vectors.
      do_expand(3, 4, K4);
      chk("model_nk4_w4", 3, 128'(exp_w[3][4]), 128'(32'ha0fafe17));
      chk("model_nk4_w43", 3, 128'(exp_w[3][43]), 128'(32'hb6630ca6));
      do_expand(3, 6, K6);
      chk("model_nk6_w6", 3, 128'(exp_w[3][6]), 128'(32'hfe0c91f7));
      chk("model_nk6_w51", 3, 128'(exp_w[3][51]), 128'(32'h01002202));
      do_expand(3, 8, K8);
      chk("model_nk8_w8", 3, 128'(exp_w[3][8]), 128'(32'h9ba35411));
      chk("model_nk8_w12", 3, 128'(exp_w[3][12]), 128'(32'ha8b09c1a));
      chk("model_nk8_w59", 3, 128'(exp_w[3][59]), 128'(32'h706c631e));

      repeat (3) step();
      for (int j = 0; j < 3; j++) chk("rst_ready", j, 128'(kr[j]), 128'(0));
      rst = 1'b0;
      step();
      for (int j = 0; j < 3; j++) chk("post_rst_ready", j, 128'(kr[j]), 128'(1));

      // FIPS keys on all three instances; measure done latency and first round-1 read.
      key[0] = K4; key[1] = K6; key[2] = K8;
      for (int j = 0; j < 3; j++) begin
         kv[j] = 1'b1;
         dl[j] = -1;
      end
      rd[0] = 4'd1;
      fv = -1;
      step();
      for (int j = 0; j < 3; j++) kv[j] = 1'b0;
      for (int e = 1; e <= 60; e++) begin
         step();
         for (int j = 0; j < 3; j++) if (dn[j] && dl[j] < 0) dl[j] = e;
         if (rv[0] && fv < 0) fv = e;
      end
      for (int j = 0; j < 3; j++) chk("done_latency", j, 128'(dl[j]), 128'(DLAT[j]));
      chk("round1_first_valid", 0, 128'(fv), 128'(EARLY ? 5 : 41));

      rd[0] = 4'd10; rd[1] = 4'd12; rd[2] = 4'd14;
      step();
      chk("nk4_round10", 0, rk[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("nk6_w51", 1, 128'(rk[1][31:0]), 128'(32'h01002202));
      chk("nk8_w59", 2, 128'(rk[2][31:0]), 128'(32'h706c631e));
      rd[0] = 4'd11; rd[1] = 4'd1; rd[2] = 4'd2;
      step();
      chk("nk4_r11_valid", 0, 128'(rv[0]), 128'(0));
      chk("nk4_r11_key", 0, rk[0], 128'(0));
      chk("nk6_w6", 1, 128'(rk[1][63:32]), 128'(32'hfe0c91f7));
      chk("nk8_w8", 2, 128'(rk[2][127:96]), 128'(32'h9ba35411));
      rd[2] = 4'd3;
      step();
      chk("nk8_w12", 2, 128'(rk[2][127:96]), 128'(32'ha8b09c1a));

      // Second key held valid during expansion is taken only on the first DONE cycle.
      key[0] = rnd256();
      kv[0]  = 1'b1;
      step();
      kb = rnd256();
      key[0] = kb;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 39) begin
            chk("hold_done_early", 0, 128'(dn[0]), 128'(0));
            chk("hold_ready", 0, 128'(kr[0]), 128'(0));
         end
      end
      chk("hold_done", 0, 128'(dn[0]), 128'(1));
      chk("hold_ready_done", 0, 128'(kr[0]), 128'(1));
      step();
      kv[0] = 1'b0;
      chk("rekey_done_drop", 0, 128'(dn[0]), 128'(0));
      chk("rekey_ready_drop", 0, 128'(kr[0]), 128'(0));
      repeat (40) step();
      chk("rekey_done", 0, 128'(dn[0]), 128'(1));
      do_expand(3, 4, {128'h0, kb[127:0]});
      rd[0] = 4'd10;
      step();
      chk("rekey_round10", 0, rk[0], {exp_w[3][40], exp_w[3][41], exp_w[3][42], exp_w[3][43]});

      // Reset in the middle of an expansion.
      key[0] = rnd256();
      kv[0]  = 1'b1;
      step();
      kv[0] = 1'b0;
      repeat (19) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_done", 0, 128'(dn[0]), 128'(0));
      chk("abort_rd_valid", 0, 128'(rv[0]), 128'(0));
      chk("abort_ready", 0, 128'(kr[0]), 128'(0));
      step();
      chk("abort_ready_back", 0, 128'(kr[0]), 128'(1));
      key[0] = K4;
      kv[0]  = 1'b1;
      step();
      kv[0] = 1'b0;
      repeat (41) step();
      chk("after_abort_w43", 0, 128'(rk[0][31:0]), 128'(32'hb6630ca6));
      chk("after_abort_valid", 0, 128'(rv[0]), 128'(1));

      // Random keys, reads and occasional resets, checked each cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         for (int j = 0; j < 3; j++) begin
            kv[j] = ($urandom_range(0, 29) == 0);
            if (kv[j]) key[j] = rnd256();
            rd[j] = 4'($urandom_range(0, 15));
         end
         step();
      end
      rst = 1'b0;
      for (int j = 0; j < 3; j++) kv[j] = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
